// File: rtl/scmp_mem_arb.sv
// scmp_mem_arb: shares a small synchronous single-port RAM between an SC/MP
// CPU bus (active-low strobes sampled on clk) and a debug port. CPU writes
// beat CPU reads, and both beat the debug port. A debug transaction is
// acknowledged with a one-cycle dbg_ack in the cycle after it completes.
module scmp_mem_arb #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_ads_n,
  input  logic              cpu_rd_n,
  input  logic              cpu_wr_n,
  input  logic [11:0]       cpu_addr,
  input  logic [7:0]        cpu_d_o,
  output logic [7:0]        cpu_d_i,
  output logic [3:0]        cpu_flags,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [7:0]        dbg_wdata,
  output logic              dbg_ack,
  output logic [7:0]        dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CPU_RD     = 3'd1,
    CPU_RD_CAP = 3'd2,
    CPU_WR     = 3'd3,
    DBG_RD     = 3'd4,
    DBG_RD_CAP = 3'd5,
    DBG_WR     = 3'd6
  } state_t;

  state_t            state_r, next_state_s;
  logic              ads_smp_r, ads_prv_r, rd_smp_r, rd_prv_r, wr_smp_r, wr_prv_r;
  logic              ads_fall_s, rd_fall_s, wr_fall_s;
  logic              rd_pend_r, wr_pend_r;
  logic [ADDR_W-1:0] rd_addr_r, wr_addr_r, rd_addr_s, wr_addr_s;
  logic [7:0]        wr_data_r, wr_data_s;
  logic              wr_go_s, rd_go_s, dbg_go_s;
  logic              unused_addr_s;

  // Only the low ADDR_W address bits reach the RAM; the rest wrap.
  assign unused_addr_s = ^cpu_addr[11:ADDR_W];

  assign ads_fall_s = ~ads_smp_r & ads_prv_r;
  assign rd_fall_s  = ~rd_smp_r & rd_prv_r;
  assign wr_fall_s  = ~wr_smp_r & wr_prv_r;

  // A fall seen this cycle is served straight away, so the live bus values
  // are used instead of the (not yet loaded) capture registers.
  assign rd_addr_s = rd_fall_s ? cpu_addr[ADDR_W-1:0] : rd_addr_r;
  assign wr_addr_s = wr_fall_s ? cpu_addr[ADDR_W-1:0] : wr_addr_r;
  assign wr_data_s = wr_fall_s ? cpu_d_o : wr_data_r;

  // A read whose strobe has already risen is dead; a read falling together
  // with a write is dropped. Debug waits out the cycle of its own ack.
  assign wr_go_s  = wr_pend_r | wr_fall_s;
  assign rd_go_s  = (rd_pend_r & ~rd_smp_r) | (rd_fall_s & ~wr_fall_s);
  assign dbg_go_s = dbg_req & ~dbg_ack;

  // Register the bus strobes once and keep the previous sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ads_smp_r <= 1'b1;
      ads_prv_r <= 1'b1;
      rd_smp_r  <= 1'b1;
      rd_prv_r  <= 1'b1;
      wr_smp_r  <= 1'b1;
      wr_prv_r  <= 1'b1;
    end else begin
      ads_smp_r <= cpu_ads_n;
      ads_prv_r <= ads_smp_r;
      rd_smp_r  <= cpu_rd_n;
      rd_prv_r  <= rd_smp_r;
      wr_smp_r  <= cpu_wr_n;
      wr_prv_r  <= wr_smp_r;
    end
  end

  // One-deep CPU request capture, status latch and pending-flag bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r <= 1'b0;
      wr_pend_r <= 1'b0;
      rd_addr_r <= {ADDR_W{1'b0}};
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= 8'h00;
      cpu_flags <= 4'h0;
    end else begin
      if (ads_fall_s) cpu_flags <= cpu_d_o[7:4];
      if (wr_fall_s) begin
        wr_addr_r <= cpu_addr[ADDR_W-1:0];
        wr_data_r <= cpu_d_o;
      end
      if (rd_fall_s && !wr_fall_s) rd_addr_r <= cpu_addr[ADDR_W-1:0];

      if (next_state_s == CPU_WR)  wr_pend_r <= 1'b0;
      else if (wr_fall_s)          wr_pend_r <= 1'b1;

      if (next_state_s == CPU_RD)          rd_pend_r <= 1'b0;
      else if (rd_fall_s && !wr_fall_s)    rd_pend_r <= 1'b1;
      else if (rd_smp_r)                   rd_pend_r <= 1'b0;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic: priority arbitration in IDLE, fixed sequences elsewhere.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (wr_go_s)       next_state_s = CPU_WR;
        else if (rd_go_s)  next_state_s = CPU_RD;
        else if (dbg_go_s) next_state_s = dbg_we ? DBG_WR : DBG_RD;
        else               next_state_s = IDLE;
      end
      CPU_RD: begin
        if (rd_smp_r) next_state_s = IDLE;
        else          next_state_s = CPU_RD_CAP;
      end
      CPU_RD_CAP: next_state_s = IDLE;
      CPU_WR:     next_state_s = IDLE;
      DBG_RD:     next_state_s = DBG_RD_CAP;
      DBG_RD_CAP: next_state_s = IDLE;
      DBG_WR:     next_state_s = IDLE;
      default:    next_state_s = IDLE;
    endcase
  end

  // Registered RAM drive, read-data return to both masters and debug ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= 8'h00;
      dbg_ack   <= 1'b0;
      dbg_rdata <= 8'h00;
      cpu_d_i   <= 8'hFF;
    end else begin
      mem_we  <= (next_state_s == CPU_WR) || (next_state_s == DBG_WR);
      dbg_ack <= (state_r == DBG_WR) || (state_r == DBG_RD_CAP);
      case (next_state_s)
        CPU_WR: begin
          mem_addr  <= wr_addr_s;
          mem_wdata <= wr_data_s;
        end
        CPU_RD: mem_addr <= rd_addr_s;
        DBG_WR: begin
          mem_addr  <= dbg_addr;
          mem_wdata <= dbg_wdata;
        end
        DBG_RD: mem_addr <= dbg_addr;
        default: begin
          mem_addr  <= mem_addr;
          mem_wdata <= mem_wdata;
        end
      endcase
      if (state_r == DBG_RD_CAP) dbg_rdata <= mem_rdata;
      // Bus floats high whenever RD is released; a cancelled read never loads.
      if (rd_smp_r)                    cpu_d_i <= 8'hFF;
      else if (state_r == CPU_RD_CAP)  cpu_d_i <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_scmp_mem_arb.sv
// Directed bench for scmp_mem_arb: a table of CPU/debug transactions with
// hand-computed results, plus sequences for arbitration, cancellation,
// same-edge RD/WR, busy-port latency and reset during a write.
module tb_scmp_mem_arb;
  localparam int ADDR_W = 5;
  localparam int OP_ADS = 0;
  localparam int OP_CWR = 1;
  localparam int OP_CRD = 2;
  localparam int OP_DWR = 3;
  localparam int OP_DRD = 4;

  logic              clk, rst_n, cpu_ads_n, cpu_rd_n, cpu_wr_n;
  logic [11:0]       cpu_addr;
  logic [7:0]        cpu_d_o, cpu_d_i;
  logic [3:0]        cpu_flags;
  logic              dbg_req, dbg_we, dbg_ack;
  logic [ADDR_W-1:0] dbg_addr, mem_addr;
  logic [7:0]        dbg_wdata, dbg_rdata, mem_wdata, mem_rdata;
  logic              mem_we;

  logic [7:0]        ram [0:31];
  int                checks = 0;
  int                failures = 0;
  int                we_cnt = 0;
  int                ack_cnt = 0;
  int                consec = 0;
  logic              prev_we = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [7:0]        last_data = 8'h00;

  typedef struct {
    int          op;
    logic [11:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [12];

  scmp_mem_arb #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_ads_n(cpu_ads_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_addr(cpu_addr), .cpu_d_o(cpu_d_o), .cpu_d_i(cpu_d_i), .cpu_flags(cpu_flags),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Synchronous single-port RAM: read data one clock after address.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  // Write-pulse and ack monitor.
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt    = we_cnt + 1;
      last_addr = mem_addr;
      last_data = mem_wdata;
    end
    if (mem_we && prev_we) consec = consec + 1;
    prev_we = mem_we;
    if (dbg_ack) ack_cnt = ack_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_ads(input logic [7:0] d, input logic [7:0] exp);
    int w0;
    w0 = we_cnt;
    cpu_d_o = d;
    cpu_ads_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ads_flags", cpu_flags, exp);
    cpu_ads_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ads_no_we", we_cnt - w0, 0);
  endtask

  task automatic do_cpu_rd(input logic [11:0] a, input logic [7:0] exp);
    int lat, w0;
    lat = 0;
    w0 = we_cnt;
    cpu_addr = a;
    cpu_rd_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (lat == 0 && cpu_d_i !== 8'hFF) lat = i;
    end
    chk("rd_latency", lat, 4);
    chk("rd_data", cpu_d_i, exp);
    chk("rd_mem_addr", mem_addr, a[ADDR_W-1:0]);
    cpu_rd_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rd_release_ff", cpu_d_i, 8'hFF);
    chk("rd_no_we", we_cnt - w0, 0);
  endtask

  task automatic do_cpu_wr(input logic [11:0] a, input logic [7:0] d);
    int w0;
    w0 = we_cnt;
    cpu_addr = a;
    cpu_d_o = d;
    cpu_wr_n = 1'b0;
    repeat (3) @(negedge clk);
    cpu_wr_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("wr_one_pulse", we_cnt - w0, 1);
    chk("wr_addr", last_addr, a[ADDR_W-1:0]);
    chk("wr_data", last_data, d);
  endtask

  task automatic do_dbg(input logic we, input logic [ADDR_W-1:0] a,
                        input logic [7:0] wd, input logic [7:0] exp);
    int a0, w0, lat, i;
    logic got;
    a0 = ack_cnt;
    w0 = we_cnt;
    got = 1'b0;
    lat = 0;
    i = 0;
    dbg_we = we;
    dbg_addr = a;
    dbg_wdata = wd;
    dbg_req = 1'b1;
    while (!got && i < 20) begin
      @(negedge clk);
      i = i + 1;
      if (dbg_ack === 1'b1) begin
        got = 1'b1;
        lat = i;
        dbg_req = 1'b0;
      end
    end
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("dbg_ack_seen", got, 1'b1);
    chk("dbg_ack_once", ack_cnt - a0, 1);
    if (we) begin
      chk("dbg_wr_latency", lat, 2);
      chk("dbg_wr_pulse", we_cnt - w0, 1);
      chk("dbg_wr_addr", last_addr, a);
      chk("dbg_wr_data", last_data, wd);
    end else begin
      chk("dbg_rd_latency", lat, 3);
      chk("dbg_rd_data", dbg_rdata, exp);
      chk("dbg_rd_no_we", we_cnt - w0, 0);
    end
  endtask

  // Steps n cycles, noting when cpu_d_i first loads and when dbg_ack arrives.
  task automatic watch(input int n, output int rd_cyc, output int ack_cyc);
    rd_cyc = 0;
    ack_cyc = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (rd_cyc == 0 && cpu_d_i !== 8'hFF) rd_cyc = i;
      if (ack_cyc == 0 && dbg_ack === 1'b1) begin
        ack_cyc = i;
        dbg_req = 1'b0;
      end
    end
  endtask

  initial begin
    int rc, ac, a0, w0, bad;
    for (int i = 0; i < 32; i++) ram[i] = 8'h00;
    ram[5] = 8'h3C;

    vecs[0]  = '{OP_ADS, 12'h000, 8'hA0, 8'h0A};
    vecs[1]  = '{OP_ADS, 12'h000, 8'h5F, 8'h05};
    vecs[2]  = '{OP_CRD, 12'h025, 8'h00, 8'h3C};
    vecs[3]  = '{OP_CWR, 12'h007, 8'h55, 8'h00};
    vecs[4]  = '{OP_DRD, 12'h007, 8'h00, 8'h55};
    vecs[5]  = '{OP_DWR, 12'h00C, 8'h9A, 8'h00};
    vecs[6]  = '{OP_CRD, 12'h00C, 8'h00, 8'h9A};
    vecs[7]  = '{OP_CWR, 12'h3E5, 8'hC3, 8'h00};
    vecs[8]  = '{OP_CRD, 12'h005, 8'h00, 8'hC3};
    vecs[9]  = '{OP_DRD, 12'h005, 8'h00, 8'hC3};
    vecs[10] = '{OP_CWR, 12'h01F, 8'h81, 8'h00};
    vecs[11] = '{OP_DRD, 12'h01F, 8'h00, 8'h81};

    rst_n = 1'b0;
    cpu_ads_n = 1'b1;
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    cpu_addr = 12'h000;
    cpu_d_o = 8'h00;
    dbg_req = 1'b0;
    dbg_we = 1'b0;
    dbg_addr = '0;
    dbg_wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_cpu_d_i", cpu_d_i, 8'hFF);
    chk("rst_flags", cpu_flags, 4'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_dbg_ack", dbg_ack, 1'b0);
    chk("rst_mem_addr", mem_addr, 5'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      case (vecs[v].op)
        OP_ADS:  do_ads(vecs[v].data, vecs[v].exp);
        OP_CWR:  do_cpu_wr(vecs[v].addr, vecs[v].data);
        OP_CRD:  do_cpu_rd(vecs[v].addr, vecs[v].exp);
        OP_DWR:  do_dbg(1'b1, vecs[v].addr[ADDR_W-1:0], vecs[v].data, 8'h00);
        default: do_dbg(1'b0, vecs[v].addr[ADDR_W-1:0], 8'h00, vecs[v].exp);
      endcase
    end

    // Debug write requested in the same cycle the CPU read fall is seen.
    a0 = ack_cnt;
    w0 = we_cnt;
    cpu_addr = 12'h00C;
    cpu_rd_n = 1'b0;
    @(negedge clk);
    dbg_we = 1'b1;
    dbg_addr = 5'd3;
    dbg_wdata = 8'h77;
    dbg_req = 1'b1;
    watch(10, rc, ac);
    chk("arb_cpu_rd_cycle", rc, 3);
    chk("arb_cpu_rd_data", cpu_d_i, 8'h9A);
    chk("arb_ack_cycle", ac, 5);
    chk("arb_ack_once", ack_cnt - a0, 1);
    chk("arb_one_write", we_cnt - w0, 1);
    chk("arb_ram3", ram[3], 8'h77);
    dbg_req = 1'b0;
    cpu_rd_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read strobe released after one clock: read cancelled, FSM back to idle.
    w0 = we_cnt;
    bad = 0;
    cpu_addr = 12'h00C;
    cpu_rd_n = 1'b0;
    @(negedge clk);
    cpu_rd_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_d_i !== 8'hFF) bad = bad + 1;
    end
    chk("cancel_no_update", bad, 0);
    chk("cancel_no_we", we_cnt - w0, 0);
    do_dbg(1'b0, 5'h0C, 8'h00, 8'h9A);

    // RD and WR falls at the same edge: write only.
    w0 = we_cnt;
    bad = 0;
    cpu_addr = 12'h00A;
    cpu_d_o = 8'h4B;
    cpu_rd_n = 1'b0;
    cpu_wr_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_d_i !== 8'hFF) bad = bad + 1;
    end
    chk("rdwr_read_dropped", bad, 0);
    chk("rdwr_one_write", we_cnt - w0, 1);
    chk("rdwr_addr", last_addr, 5'h0A);
    chk("rdwr_data", last_data, 8'h4B);
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    repeat (2) @(negedge clk);

    // CPU read arriving while a debug read is already under way.
    cpu_addr = 12'h01F;
    cpu_rd_n = 1'b0;
    dbg_we = 1'b0;
    dbg_addr = 5'h07;
    dbg_req = 1'b1;
    watch(12, rc, ac);
    chk("busy_rd_cycle", rc, 6);
    chk("busy_rd_data", cpu_d_i, 8'h81);
    chk("busy_ack_cycle", ac, 3);
    chk("busy_dbg_data", dbg_rdata, 8'h55);
    dbg_req = 1'b0;
    cpu_rd_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted while CPU_WR drives the RAM.
    w0 = we_cnt;
    cpu_addr = 12'h011;
    cpu_d_o = 8'hEE;
    cpu_wr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("prerst_we_active", mem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_we", mem_we, 1'b0);
    chk("rst_mid_cpu_d_i", cpu_d_i, 8'hFF);
    chk("rst_mid_flags", cpu_flags, 4'h0);
    chk("rst_mid_dbg_ack", dbg_ack, 1'b0);
    chk("rst_mid_dbg_rdata", dbg_rdata, 8'h00);
    chk("rst_mid_mem_addr", mem_addr, 5'd0);
    chk("rst_mid_mem_wdata", mem_wdata, 8'h00);
    cpu_wr_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_write", we_cnt - w0, 0);
    chk("rst_mid_ram17", ram[17], 8'h00);

    chk("no_consecutive_we", consec, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
